pc_unit: RTL and testbench

//   Parametrised program counter: the sequential successor to the mux/dmux gate layer.

---
 rtl/pc_unit.sv | 141 ++++++++++++++
 tb/tb_pc_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter: clear/load/call/return/increment/hold, strict priority.
// Return-address stack is built only when PC_RAS_EN is defined.
module pc_unit #(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] STEP         =
    {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_addr,
  input  logic             inc,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic             wrap,
  output logic             ras_full,
  output logic             ras_empty,
  output logic             ras_err
);

  if (WIDTH < 2 || RAS_DEPTH < 1) begin : g_param_chk
    $error("pc_unit: bad parameters");
  end

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nxt;

  assign sum = {1'b0, pc_q} + {1'b0, STEP};
  assign nxt = sum[WIDTH-1:0];

`ifdef PC_RAS_EN
  localparam int unsigned PW =
    (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);

  // Circular buffer: a push when full overwrites the oldest slot.
  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]    sp_q, sp_d, sp_inc, sp_dec;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push;
  logic             full, empty;

  assign sp_inc = (sp_q == LAST) ? '0 : sp_q + 1'b1;
  assign sp_dec = (sp_q == '0) ? LAST : sp_q - 1'b1;
  assign full   = (cnt_q == FULL);
  assign empty  = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (push) mem_q[sp_q] <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  assign ras_full  = full;
  assign ras_empty = empty;
`else
  assign ras_full  = 1'b0;
  assign ras_empty = 1'b1;
`endif

  always_comb begin
    pc_d   = pc_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
`ifdef PC_RAS_EN
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    push   = 1'b0;
`endif
    priority case (1'b1)
      clr: begin
        pc_d = RESET_VECTOR;
`ifdef PC_RAS_EN
        sp_d  = '0;
        cnt_d = '0;
`endif
      end
      load: pc_d = ld_addr;
`ifdef PC_RAS_EN
      call: begin
        pc_d = ld_addr;
        push = 1'b1;
        sp_d = sp_inc;
        if (full) err_d = 1'b1;
        else      cnt_d = cnt_q + 1'b1;
      end
      ret: begin
        if (empty) begin
          err_d = 1'b1;
        end else begin
          pc_d  = mem_q[sp_dec];
          sp_d  = sp_dec;
          cnt_d = cnt_q - 1'b1;
        end
      end
`else
      call: pc_d = ld_addr;
      ret:  pc_d = pc_q;
`endif
      inc: begin
        pc_d   = nxt;
        wrap_d = sum[WIDTH];
      end
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_VECTOR;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign pc      = pc_q;
  assign wrap    = wrap_q;
  assign ras_err = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: driver queues expectations,
// a negedge monitor pops and compares them.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0, load = 1'b0, inc = 1'b0;
  logic        call = 1'b0, ret = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [15:0] pc;
  logic        wrap, ras_full, ras_empty, ras_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] pc;
    logic        w, f, e, r;
    int          due;
    string       nm;
  } exp_t;

  exp_t sbq[$];

  pc_unit dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load),
    .ld_addr(ld_addr), .inc(inc), .call(call), .ret(ret),
    .pc(pc), .wrap(wrap), .ras_full(ras_full),
    .ras_empty(ras_empty), .ras_err(ras_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic cmp(input string nm, input logic [19:0] got,
                     input logic [19:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got pc/w/f/e/r=%h/%b/%b/%b/%b want %h/%b/%b/%b/%b",
        nm, got[19:4], got[3], got[2], got[1], got[0],
        want[19:4], want[3], want[2], want[1], want[0]);
    end
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      exp_t x;
      x = sbq.pop_front();
      cmp(x.nm, {pc, wrap, ras_full, ras_empty, ras_err},
          {x.pc, x.w, x.f, x.e, x.r});
    end
  end

  // cmd bits: {clr, load, call, ret, inc}
  task automatic issue(input logic [4:0] cmd, input logic [15:0] a,
                       input logic [15:0] epc, input logic [3:0] fl,
                       input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    {clr, load, call, ret, inc} = cmd;
    ld_addr = a;
    x.pc = epc;
    {x.w, x.f, x.e, x.r} = fl;
    x.due = cyc + 1;
    x.nm = nm;
    sbq.push_back(x);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    {clr, load, call, ret, inc} = '0;
  endtask

  localparam logic [4:0] C_CLR = 5'b10000;
  localparam logic [4:0] C_LD  = 5'b01000;
  localparam logic [4:0] C_CAL = 5'b00100;
  localparam logic [4:0] C_RET = 5'b00010;
  localparam logic [4:0] C_INC = 5'b00001;
  localparam logic [4:0] C_NOP = 5'b00000;
  // flags: {wrap, full, empty, err}
  localparam logic [3:0] F_IDL = 4'b0010;
  localparam logic [3:0] F_WRP = 4'b1010;

  initial begin
    #2;
    cmp("reset_init", {pc, wrap, ras_full, ras_empty, ras_err},
        {16'h0000, F_IDL});
    @(negedge clk);
    rst_n = 1'b1;

    issue(C_LD, 16'h1234, 16'h1234, F_IDL, "load_1234");
    idle();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    cmp("async_reset", {pc, wrap, ras_full, ras_empty, ras_err},
        {16'h0000, F_IDL});
    #1 rst_n = 1'b1;

    issue(C_LD, 16'h0100, 16'h0100, F_IDL, "load_0100");
    issue(C_INC, 16'h0, 16'h0101, F_IDL, "inc_1");
    issue(C_INC, 16'h0, 16'h0102, F_IDL, "inc_2");
    issue(C_INC, 16'h0, 16'h0103, F_IDL, "inc_3");
    issue(C_LD | C_INC, 16'h0200, 16'h0200, F_IDL, "load_over_inc");
    issue(C_NOP, 16'h5555, 16'h0200, F_IDL, "hold");
    issue(C_LD, 16'hFFFF, 16'hFFFF, F_IDL, "load_ffff");
    issue(C_INC, 16'h0, 16'h0000, F_WRP, "inc_wrap");
    issue(C_NOP, 16'h0, 16'h0000, F_IDL, "wrap_pulse_end");
    issue(C_INC, 16'h0, 16'h0001, F_IDL, "inc_after_wrap");
    issue(C_LD, 16'hFFFF, 16'hFFFF, F_IDL, "load_ffff_b");
    issue(C_INC, 16'h0, 16'h0000, F_WRP, "inc_wrap_b");
    issue(C_INC, 16'h0, 16'h0001, F_IDL, "inc_nowrap");
    issue(C_CLR | C_LD | C_INC, 16'h4444, 16'h0000, F_IDL,
          "clr_over_all");
    issue(C_LD | C_CAL, 16'h0ABC, 16'h0ABC, F_IDL, "load_over_call");

`ifdef PC_RAS_EN
    issue(C_LD, 16'h0010, 16'h0010, 4'b0010, "ras_load_10");
    issue(C_CAL, 16'h0020, 16'h0020, 4'b0000, "call_20");
    issue(C_CAL, 16'h0030, 16'h0030, 4'b0000, "call_30");
    issue(C_CAL, 16'h0040, 16'h0040, 4'b0000, "call_40");
    issue(C_CAL, 16'h0050, 16'h0050, 4'b0100, "call_50_full");
    issue(C_CAL | C_RET, 16'h0060, 16'h0060, 4'b0101,
          "call_60_ovf");
    issue(C_NOP, 16'h0, 16'h0060, 4'b0100, "err_pulse_end");
    issue(C_RET | C_INC, 16'h0, 16'h0051, 4'b0000, "ret_51");
    issue(C_RET, 16'h0, 16'h0041, 4'b0000, "ret_41");
    issue(C_RET, 16'h0, 16'h0031, 4'b0000, "ret_31");
    issue(C_RET, 16'h0, 16'h0021, 4'b0010, "ret_21_empty");
    issue(C_LD, 16'h0077, 16'h0077, 4'b0010, "load_77");
    issue(C_RET, 16'h0, 16'h0077, 4'b0011, "ret_empty_err");
    issue(C_NOP, 16'h0, 16'h0077, 4'b0010, "ret_err_end");
    issue(C_CAL, 16'h0100, 16'h0100, 4'b0000, "call_100");
    issue(C_CAL, 16'h0200, 16'h0200, 4'b0000, "call_200");
    issue(C_CLR, 16'h0, 16'h0000, 4'b0010, "clr_ras");
    issue(C_RET, 16'h0, 16'h0000, 4'b0011, "ret_after_clr");
`else
    issue(C_CAL, 16'h0200, 16'h0200, F_IDL, "call_as_load");
    issue(C_RET, 16'h0, 16'h0200, F_IDL, "ret_as_hold");
    issue(C_RET | C_INC, 16'h0, 16'h0200, F_IDL, "ret_over_inc");
    issue(C_CAL | C_INC, 16'h0300, 16'h0300, F_IDL, "call_over_inc");
    issue(C_INC, 16'h0, 16'h0301, F_IDL, "inc_after_call");
`endif

    idle();
    repeat (4) @(negedge clk);
    if (sbq.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left, want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
